// File: rtl/key_event_queue_if.sv
// Keyboard event bus between the PS/2 toggle source and the key replay queue.
interface key_event_queue_if #(
    parameter int DEPTH = 8
);
    logic [10:0]              ps2_key;
    logic                     flush;
    logic                     key_ready;
    logic                     key_stroke;
    logic [9:0]               key_code;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output ps2_key, flush,
        input  key_ready, key_stroke, key_code, overflow, level
    );

    modport slave (
        input  ps2_key, flush,
        output key_ready, key_stroke, key_code, overflow, level
    );
endinterface

// File: rtl/key_event_queue.sv
// Queues ps2_key toggle events, drops consecutive duplicates and replays them as paced key_ready strobes.
// Latency: strobe one edge after the event is captured. No backpressure: a full FIFO drops the event and sets sticky overflow.
module key_event_queue #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 64
) (
    input logic              clk_sys,
    input logic              reset_n,
    key_event_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_gap_cnt;
    logic [GW-1:0] w_gap_nxt;

    logic          r_primed;
    logic          r_tog_q;
    logic          r_filt_vld;
    logic [9:0]    r_last;
    logic          r_overflow;

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic          r_key_ready;
    logic          r_key_stroke;
    logic [9:0]    r_key_code;

    logic          w_event;
    logic [9:0]    w_word;
    logic          w_accept;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [9:0]    w_rd;

    assign w_word   = bus.ps2_key[9:0];
    assign w_event  = r_primed && (bus.ps2_key[10] != r_tog_q);
    assign w_accept = w_event && !bus.flush && !(r_filt_vld && (w_word == r_last));
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LW'(DEPTH));
    // A pop on the same edge frees a slot, so a full FIFO can still take the push.
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_rd     = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                w_state_nxt = S_GAP;
                w_gap_nxt   = GW'(GAP_CYCLES - 1);
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_STROBE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush) begin
            w_pop       = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    // The first edge after reset only samples the toggle level, so no event is generated.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_primed   <= 1'b0;
            r_tog_q    <= 1'b0;
            r_filt_vld <= 1'b0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            r_tog_q  <= bus.ps2_key[10];
            if (bus.flush) begin
                r_filt_vld <= 1'b0;
                r_overflow <= 1'b0;
            end else if (w_accept) begin
                r_filt_vld <= 1'b1;
                r_last     <= w_word;
                if (!w_push) r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // key_code and key_stroke hold between strobes; only reset clears them.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_key_ready  <= 1'b0;
            r_key_stroke <= 1'b0;
            r_key_code   <= '0;
        end else begin
            r_key_ready <= w_pop;
            if (w_pop) begin
                r_key_stroke <= w_rd[9];
                r_key_code   <= {1'b0, w_rd[8:0]};
            end
        end
    end

    assign bus.key_ready  = r_key_ready;
    assign bus.key_stroke = r_key_stroke;
    assign bus.key_code   = r_key_code;
    assign bus.overflow   = r_overflow;
    assign bus.level      = r_level;
endmodule
